// File: rtl/sdrc_mp_arb_if.sv
// Controller-side request/data bus between the multi-port arbiter and the SDRAM controller.
// The arbiter drives requests through the master modport and the controller answers through the slave modport.
interface sdrc_mp_arb_if #(
    parameter int APP_AW = 26,
    parameter int APP_DW = 32,
    parameter int APP_BW = 4,
    parameter int BL     = 9
);
    logic              app_req;
    logic [APP_AW-1:0] app_req_addr;
    logic [BL-1:0]     app_req_len;
    logic              app_req_wr_n;
    logic [APP_DW-1:0] app_wr_data;
    logic [APP_BW-1:0] app_wr_en_n;
    logic              app_req_ack;
    logic              app_wr_next_req;
    logic              app_rd_valid;
    logic              app_last_rd;
    logic              app_last_wr;
    logic [APP_DW-1:0] app_rd_data;

    modport master (
        output app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data, app_wr_en_n,
        input  app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd, app_last_wr, app_rd_data
    );

    modport slave (
        input  app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data, app_wr_en_n,
        output app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd, app_last_wr, app_rd_data
    );
endinterface

// File: rtl/sdrc_mp_arb.sv
// Round-robin multi-port request arbiter for the SDRAM controller, with per-direction port-tag queues routing data beats.
// Optional macro SDRC_MP_PORT0_PRIO_EN: port 0 always wins when eligible, ports 1..NPORT-1 round-robin among themselves.
module sdrc_mp_arb #(
    parameter int NPORT    = 4,
    parameter int APP_AW   = 26,
    parameter int APP_DW   = 32,
    parameter int APP_BW   = 4,
    parameter int BL       = 9,
    parameter int TQ_DEPTH = 4
) (
    input  logic                     sdram_clk,
    input  logic                     sdram_resetn,
    input  logic [NPORT-1:0]         p_req,
    input  logic [NPORT*APP_AW-1:0]  p_req_addr,
    input  logic [NPORT*BL-1:0]      p_req_len,
    input  logic [NPORT-1:0]         p_req_wr_n,
    input  logic [NPORT*APP_DW-1:0]  p_wr_data,
    input  logic [NPORT*APP_BW-1:0]  p_wr_en_n,
    output logic [NPORT-1:0]         p_req_ack,
    output logic [NPORT-1:0]         p_wr_next,
    output logic [NPORT-1:0]         p_rd_valid,
    output logic [NPORT-1:0]         p_last_rd,
    output logic [APP_DW-1:0]        p_rd_data,
    sdrc_mp_arb_if.master            app,
    output logic                     tag_err,
    output logic                     busy
);
    // state | meaning
    // IDLE  | no request outstanding; arbitrate among eligible ports
    // ISSUE | app_req held with the winner's fields until app_req_ack

    localparam int PW  = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int TAW = $clog2(TQ_DEPTH);
    localparam int CW  = TAW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state;
    logic [PW-1:0]   grant;
    logic [PW-1:0]   last_gnt;
    logic [PW-1:0]   win;
    logic            found;
    logic [NPORT-1:0] elig;

    logic [PW-1:0]   wr_q [TQ_DEPTH];
    logic [PW-1:0]   rd_q [TQ_DEPTH];
    logic [TAW-1:0]  wr_wptr, wr_rptr, rd_wptr, rd_rptr;
    logic [CW-1:0]   wr_cnt, rd_cnt;
    logic            wr_push, rd_push, wr_pop_req, rd_pop_req, wr_pop, rd_pop;
    logic [PW-1:0]   wr_head, rd_head;

    // Eligibility uses the registered counts, so a pop in this cycle never frees a slot early.
    always_comb begin
        found = 1'b0;
        win   = last_gnt;
        for (int p = 0; p < NPORT; p++)
            elig[p] = p_req[p] && (p_req_wr_n[p] ? (rd_cnt < CW'(TQ_DEPTH)) : (wr_cnt < CW'(TQ_DEPTH)));
        for (int i = 1; i <= NPORT; i++) begin
            if (!found && elig[(int'(last_gnt) + i) % NPORT]) begin
                found = 1'b1;
                win   = PW'((int'(last_gnt) + i) % NPORT);
            end
        end
`ifdef SDRC_MP_PORT0_PRIO_EN
        if (elig[0]) win = '0;
`endif
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state            <= IDLE;
            app.app_req      <= 1'b0;
            app.app_req_addr <= '0;
            app.app_req_len  <= '0;
            app.app_req_wr_n <= 1'b1;
            grant            <= '0;
            last_gnt         <= PW'(NPORT - 1);
        end else begin
            case (state)
                IDLE: if (found) begin
                    state            <= ISSUE;
                    app.app_req      <= 1'b1;
                    app.app_req_addr <= p_req_addr[int'(win)*APP_AW +: APP_AW];
                    app.app_req_len  <= p_req_len[int'(win)*BL +: BL];
                    app.app_req_wr_n <= p_req_wr_n[win];
                    grant            <= win;
`ifdef SDRC_MP_PORT0_PRIO_EN
                    // Port 0 wins outside the rotation, so it does not move the pointer.
                    if (win != '0) last_gnt <= win;
`else
                    last_gnt <= win;
`endif
                end
                ISSUE: if (app.app_req_ack) begin
                    state       <= IDLE;
                    app.app_req <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        p_req_ack = '0;
        if ((state == ISSUE) && app.app_req_ack) p_req_ack[grant] = 1'b1;
    end

    assign wr_push    = (state == ISSUE) && app.app_req_ack && !app.app_req_wr_n;
    assign rd_push    = (state == ISSUE) && app.app_req_ack &&  app.app_req_wr_n;
    assign wr_pop_req = app.app_wr_next_req && app.app_last_wr;
    assign rd_pop_req = app.app_rd_valid && app.app_last_rd;
    assign wr_pop     = wr_pop_req && (wr_cnt != '0);
    assign rd_pop     = rd_pop_req && (rd_cnt != '0);

    always_ff @(posedge sdram_clk) begin
        if (wr_push) wr_q[wr_wptr] <= grant;
        if (rd_push) rd_q[rd_wptr] <= grant;
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            wr_wptr <= '0;
            wr_rptr <= '0;
            wr_cnt  <= '0;
            rd_wptr <= '0;
            rd_rptr <= '0;
            rd_cnt  <= '0;
            tag_err <= 1'b0;
        end else begin
            if (wr_push) wr_wptr <= wr_wptr + TAW'(1);
            if (wr_pop)  wr_rptr <= wr_rptr + TAW'(1);
            if (rd_push) rd_wptr <= rd_wptr + TAW'(1);
            if (rd_pop)  rd_rptr <= rd_rptr + TAW'(1);
            wr_cnt <= wr_cnt + CW'(wr_push) - CW'(wr_pop);
            rd_cnt <= rd_cnt + CW'(rd_push) - CW'(rd_pop);
            if ((wr_pop_req && (wr_cnt == '0)) || (rd_pop_req && (rd_cnt == '0))) tag_err <= 1'b1;
        end
    end

    assign wr_head = wr_q[wr_rptr];
    assign rd_head = rd_q[rd_rptr];

    always_comb begin
        p_wr_next       = '0;
        p_rd_valid      = '0;
        p_last_rd       = '0;
        app.app_wr_data = '0;
        app.app_wr_en_n = '1;
        if (wr_cnt != '0) begin
            p_wr_next[wr_head] = app.app_wr_next_req;
            app.app_wr_data    = p_wr_data[int'(wr_head)*APP_DW +: APP_DW];
            app.app_wr_en_n    = p_wr_en_n[int'(wr_head)*APP_BW +: APP_BW];
        end
        if (rd_cnt != '0) begin
            p_rd_valid[rd_head] = app.app_rd_valid;
            p_last_rd[rd_head]  = app.app_last_rd;
        end
    end

    assign p_rd_data = app.app_rd_data;
    assign busy      = (wr_cnt != '0) || (rd_cnt != '0) || app.app_req;

endmodule
